// File: rtl/matvec_engine_farm.sv
// Round-robin dispatcher/collector for an external bank of matrix-vector engines.
// Output framing is rebuilt from a queued per-value size header; optional engine bypass.
module matvec_engine_farm #(
  parameter int ENGINES_NO    = 6,
  parameter int VECTOR_SIZE   = 3,
  parameter int ENTRY_SIZE    = 64,
  parameter int SIZE_BYTES    = 2,
  parameter int HDR_ADDR_BITS = 5
) (
  input  logic                                                        clk,
  input  logic                                                        rst,
  input  logic                                                        cfg_bypass,
  input  logic [VECTOR_SIZE*VECTOR_SIZE*ENTRY_SIZE-1:0]               in_matrix,
  input  logic [VECTOR_SIZE*ENTRY_SIZE-1:0]                           in_vector,
  input  logic [8*SIZE_BYTES-1:0]                                     in_size,
  input  logic                                                        in_valid,
  output logic                                                        in_ready,
  input  logic                                                        in_last,
  output logic [8*SIZE_BYTES-1:0]                                     out_size,
  output logic [VECTOR_SIZE*ENTRY_SIZE-1:0]                           out_data,
  output logic                                                        out_valid,
  input  logic                                                        out_ready,
  output logic                                                        out_last,
  output logic [ENGINES_NO*(VECTOR_SIZE*VECTOR_SIZE+VECTOR_SIZE)*ENTRY_SIZE-1:0] eng_in_data,
  output logic [ENGINES_NO-1:0]                                       eng_in_valid,
  input  logic [ENGINES_NO-1:0]                                       eng_in_ready,
  input  logic [ENGINES_NO*VECTOR_SIZE*ENTRY_SIZE-1:0]                eng_res_data,
  input  logic [ENGINES_NO-1:0]                                       eng_res_valid,
  output logic [ENGINES_NO-1:0]                                       eng_res_ready,
  output logic                                                        err_len,
  output logic                                                        busy
);
  localparam int VEC_W  = VECTOR_SIZE * ENTRY_SIZE;
  localparam int MAT_W  = VECTOR_SIZE * VECTOR_SIZE * ENTRY_SIZE;
  localparam int LANE_W = VEC_W + MAT_W;
  localparam int SZ_W   = 8 * SIZE_BYTES;
  localparam int BPW    = VEC_W / 8;
  localparam int PTR_W  = $clog2(ENGINES_NO);
  localparam int DEPTH  = 1 << HDR_ADDR_BITS;

  typedef enum logic [0:0] {S_IDLE, S_STREAM} state_t;

  // Words per value: the header shares the first word, so small values still take one word.
  function automatic logic [SZ_W-1:0] words_of(input logic [SZ_W-1:0] sz);
    logic [SZ_W:0] num;
    num = '0;
    if (sz <= SZ_W'(SIZE_BYTES + BPW)) return SZ_W'(1);
    num = {1'b0, sz} + (SZ_W+1)'(BPW - 1 - SIZE_BYTES);
    return SZ_W'(num / (SZ_W+1)'(BPW));
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(ENGINES_NO - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         din_q, dout_q;
  logic                     first_q, mode_q, err_q, bp_vld_q;
  logic [SZ_W-1:0]          wcnt_q, wcnt_d, cur_words_q, cur_words_d;
  logic [SZ_W-1:0]          remaining_q, remaining_d, out_size_q, out_size_d;
  logic [2*SZ_W-1:0]        hdr_mem [DEPTH];
  logic [2*SZ_W-1:0]        hdr_rd;
  logic [HDR_ADDR_BITS-1:0] wr_q, rd_q;
  logic [HDR_ADDR_BITS:0]   cnt_q;
  logic [VEC_W-1:0]         bp_data_q;
  logic                     hdr_full, hdr_empty, blk_hdr, in_hs, out_hs, push, pop;

  assign hdr_full    = (cnt_q == (HDR_ADDR_BITS+1)'(DEPTH));
  assign hdr_empty   = (cnt_q == '0);
  assign blk_hdr     = first_q && hdr_full;
  assign hdr_rd      = hdr_mem[rd_q];
  assign out_valid   = (state_q == S_STREAM) && (mode_q ? bp_vld_q : eng_res_valid[dout_q]);
  assign out_data    = mode_q ? bp_data_q : eng_res_data[dout_q*VEC_W +: VEC_W];
  assign out_hs      = out_valid && out_ready;
  assign out_last    = (state_q == S_STREAM) && (remaining_q == SZ_W'(1));
  assign out_size    = out_size_q;
  assign in_hs       = in_valid && in_ready;
  assign push        = in_hs && first_q;
  assign err_len     = err_q;
  assign busy        = !hdr_empty || (state_q == S_STREAM) || !first_q || bp_vld_q;
  assign wcnt_d      = first_q ? SZ_W'(1) : wcnt_q + SZ_W'(1);
  assign cur_words_d = first_q ? words_of(in_size) : cur_words_q;

  // Lane routing: only the pointed-to lane sees traffic; bypass leaves the engines idle.
  always_comb begin
    eng_in_valid  = '0;
    eng_in_data   = '0;
    eng_res_ready = '0;
    if (mode_q) begin
      in_ready = (!bp_vld_q || out_hs) && !blk_hdr;
    end else begin
      in_ready                              = eng_in_ready[din_q] && !blk_hdr;
      eng_in_valid[din_q]                   = in_valid && !blk_hdr;
      eng_in_data[din_q*LANE_W +: LANE_W]   = {in_vector, in_matrix};
      eng_res_ready[dout_q]                 = out_ready && (state_q == S_STREAM);
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    out_size_d  = out_size_q;
    pop         = 1'b0;
    case (state_q)
      S_IDLE: if (!hdr_empty) begin
        pop         = 1'b1;
        out_size_d  = hdr_rd[SZ_W +: SZ_W];
        remaining_d = hdr_rd[0 +: SZ_W];
        state_d     = S_STREAM;
      end
      S_STREAM: if (out_hs) begin
        remaining_d = remaining_q - SZ_W'(1);
        if (remaining_q == SZ_W'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      din_q       <= '0;
      dout_q      <= '0;
      first_q     <= 1'b1;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      bp_vld_q    <= 1'b0;
      wcnt_q      <= '0;
      cur_words_q <= '0;
      remaining_q <= '0;
      out_size_q  <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      out_size_q  <= out_size_d;
      if (in_hs) begin
        din_q       <= next_ptr(din_q);
        first_q     <= in_last;
        wcnt_q      <= wcnt_d;
        cur_words_q <= cur_words_d;
        if (in_last && (wcnt_d != cur_words_d)) err_q <= 1'b1;
      end
      if (out_hs) dout_q <= next_ptr(dout_q);
      // Mode only changes with nothing in flight, so word order and framing stay consistent.
      if (!busy && !in_hs) mode_q <= cfg_bypass;
      if (mode_q && in_hs)  bp_vld_q <= 1'b1;
      else if (out_hs)      bp_vld_q <= 1'b0;
      if (push) wr_q <= wr_q + HDR_ADDR_BITS'(1);
      if (pop)  rd_q <= rd_q + HDR_ADDR_BITS'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (HDR_ADDR_BITS+1)'(1);
        2'b01:   cnt_q <= cnt_q - (HDR_ADDR_BITS+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)          hdr_mem[wr_q] <= {in_size, cur_words_d};
    if (mode_q && in_hs) bp_data_q   <= in_vector;
  end

endmodule

// File: tb/tb_matvec_engine_farm.sv
// Bench for matvec_engine_farm: behavioural engine bank plus a word/frame scoreboard.
module tb_matvec_engine_farm;
  localparam int N = 4, V = 3, E = 64, SB = 2, HA = 1;
  localparam int VW = V*E, MW = V*V*E, LW = VW + MW, SW = 8*SB;

  logic clk = 1'b0, rst = 1'b0, cfg_bypass = 1'b0;
  logic [MW-1:0] in_matrix = '0;
  logic [VW-1:0] in_vector = '0;
  logic [SW-1:0] in_size = '0;
  logic in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [SW-1:0] out_size;
  logic [VW-1:0] out_data;
  logic out_valid, out_ready = 1'b0, out_last;
  logic [N*LW-1:0] eng_in_data;
  logic [N-1:0] eng_in_valid, eng_in_ready, eng_res_valid, eng_res_ready;
  logic [N*VW-1:0] eng_res_data;
  logic err_len, busy;

  matvec_engine_farm #(.ENGINES_NO(N), .VECTOR_SIZE(V), .ENTRY_SIZE(E),
                       .SIZE_BYTES(SB), .HDR_ADDR_BITS(HA)) dut (
    .clk(clk), .rst(rst), .cfg_bypass(cfg_bypass), .in_matrix(in_matrix),
    .in_vector(in_vector), .in_size(in_size), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .out_size(out_size), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .eng_in_data(eng_in_data),
    .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_res_data(eng_res_data),
    .eng_res_valid(eng_res_valid), .eng_res_ready(eng_res_ready), .err_len(err_len),
    .busy(busy));

  always #5 clk = ~clk;

  int nchecks = 0, nerrors = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    nchecks++;
    nerrors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [VW-1:0] matvec(input logic [MW-1:0] m, input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic [E-1:0] acc;
    for (int row = 0; row < V; row++) begin
      acc = '0;
      for (int c = 0; c < V; c++) acc = acc + m[(row*V+c)*E +: E] * v[c*E +: E];
      r[row*E +: E] = acc;
    end
    return r;
  endfunction

  function automatic int words_of(input int sz);
    if (sz <= SB + VW/8) return 1;
    return (sz - SB + VW/8 - 1) / (VW/8);
  endfunction

  // Behavioural engine bank: per-lane FIFO with random latency, flushed by rst.
  logic [VW-1:0] eq[N][$];
  int et[N][$];
  int cyc = 0;
  bit eng_force = 0;
  initial begin
    eng_in_ready = '0; eng_res_valid = '0; eng_res_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < N; i++) begin
        eng_in_ready[i] = eng_force || ($urandom_range(0, 3) != 0);
        if (eq[i].size() > 0 && et[i][0] <= cyc) begin
          eng_res_valid[i] = 1'b1;
          eng_res_data[i*VW +: VW] = eq[i][0];
        end else begin
          eng_res_valid[i] = 1'b0;
          eng_res_data[i*VW +: VW] = '0;
        end
      end
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          eq[i].delete(); et[i].delete();
        end else begin
          if (eng_in_valid[i] && eng_in_ready[i]) begin
            eq[i].push_back(matvec(eng_in_data[i*LW +: MW], eng_in_data[i*LW+MW +: VW]));
            et[i].push_back(cyc + int'($urandom_range(1, 4)));
          end
          if (eng_res_valid[i] && eng_res_ready[i]) begin
            void'(eq[i].pop_front()); void'(et[i].pop_front());
          end
        end
      end
    end
  end

  int ordy_mode = 1;
  initial forever begin
    @(negedge clk);
    out_ready = (ordy_mode == 0) ? 1'b0 : (ordy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // Reference model: global word order, headers in order, framing from header word counts.
  typedef struct { logic [SW-1:0] size; int words; } hdr_t;
  logic [VW-1:0] dataq[$];
  hdr_t hq[$];
  hdr_t cur;
  bit cur_act = 0, exp_err = 0, exp_bypass = 0, m_first = 1;
  int k = 0, exp_din = 0, m_cnt = 0, m_words = 0, pend_words = 1;

  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      dataq.delete(); hq.delete();
      cur_act = 0; exp_err = 0; exp_din = 0; m_first = 1; k = 0;
      continue;
    end
    chk("err_len", 192'(err_len), 192'(exp_err));
    if (out_valid && out_ready) begin
      if (!cur_act) begin
        if (hq.size() == 0) fail("spurious_output");
        else begin cur = hq.pop_front(); cur_act = 1; k = 0; end
      end
      if (cur_act) begin
        k++;
        chk("out_size", 192'(out_size), 192'(cur.size));
        chk("out_last", 192'(out_last), 192'(k == cur.words));
        if (dataq.size() == 0) fail("output_without_input");
        else chk("out_data", out_data, dataq.pop_front());
        if (k == cur.words) cur_act = 0;
      end
    end
    if (in_valid && in_ready) begin
      if (exp_bypass) chk("bypass_eng_idle", 192'(eng_in_valid), '0);
      else            chk("dispatch_lane", 192'(eng_in_valid), 192'(1 << exp_din));
      dataq.push_back(exp_bypass ? in_vector : matvec(in_matrix, in_vector));
      if (m_first) begin
        hq.push_back('{in_size, pend_words});
        m_cnt = 0; m_words = pend_words;
      end
      m_cnt++;
      if (in_last) begin
        if (m_cnt != m_words) exp_err = 1;
        m_first = 1;
      end else m_first = 0;
      exp_din = (exp_din + 1) % N;
    end
  end

  task automatic drive_word(input int sz, input bit last);
    in_valid = 1'b1;
    in_size = SW'(sz);
    in_last = last;
    for (int i = 0; i < MW/32; i++) in_matrix[i*32 +: 32] = $urandom;
    for (int i = 0; i < VW/32; i++) in_vector[i*32 +: 32] = $urandom;
  endtask

  task automatic wait_accept();
    for (int t = 0; ; t++) begin
      #2;
      if (in_ready) break;
      if (t > 3000) begin
        $display("FAIL input_accept_timeout at %0t", $time);
        $fatal(1, "input never accepted");
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_value(input int sz, input int nin, input int words);
    pend_words = words;
    for (int w = 0; w < nin; w++) begin
      drive_word(sz, w == nin - 1);
      wait_accept();
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int t = 0; t < 4000 && !done; t++) begin
      @(negedge clk);
      #3;
      done = (dataq.size() == 0) && (hq.size() == 0) && !cur_act;
    end
    if (!done) fail("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  typedef struct { int size; int nin; int words; } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{122, 5, 5}; tbl[1] = '{26, 1, 1}; tbl[2] = '{50, 2, 2};
    tbl[3] = '{74, 3, 3};  tbl[4] = '{0, 1, 1};  tbl[5] = '{27, 2, 2};
    tbl[6] = '{98, 4, 4};  tbl[7] = '{99, 5, 5}; tbl[8] = '{1, 1, 1};

    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 192'(out_valid), '0);
    chk("rst_out_last", 192'(out_last), '0);
    chk("rst_out_size", 192'(out_size), '0);
    chk("rst_err_len", 192'(err_len), '0);
    chk("rst_busy", 192'(busy), '0);
    chk("rst_eng_in_valid", 192'(eng_in_valid), '0);
    chk("rst_eng_res_ready", 192'(eng_res_ready), '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Table-driven values, first with a steady sink, then with a random one.
    ordy_mode = 1;
    for (int i = 0; i < 9; i++) send_value(tbl[i].size, tbl[i].nin, tbl[i].words);
    wait_drain();
    ordy_mode = 2;
    for (int i = 0; i < 9; i++) send_value(tbl[i].size, tbl[i].nin, tbl[i].words);
    wait_drain();
    chk("idle_busy", 192'(busy), '0);

    // Header queue full: a new first word must stall until the FSM pops.
    eng_force = 1; ordy_mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) send_value(20, 1, 1);
    pend_words = 1;
    drive_word(20, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #2 chk("hdr_full_stall", 192'(in_ready), '0);
      @(negedge clk);
    end
    chk("hdr_full_busy", 192'(busy), 192'(1));
    ordy_mode = 1;
    wait_accept();
    wait_drain();
    eng_force = 0;

    // Bypass mode, then a mid-value request to leave it.
    cfg_bypass = 1'b1;
    repeat (3) @(negedge clk);
    exp_bypass = 1;
    send_value(50, 2, 2);
    ordy_mode = 2;
    for (int i = 0; i < 9; i++) send_value(tbl[i].size, tbl[i].nin, tbl[i].words);
    pend_words = 3;
    drive_word(74, 1'b0); wait_accept();
    cfg_bypass = 1'b0;
    drive_word(74, 1'b0); wait_accept();
    drive_word(74, 1'b1); wait_accept();
    wait_drain();
    exp_bypass = 0;
    chk("bypass_exit_busy", 192'(busy), '0);

    // Randomised values in engine mode, then in bypass mode.
    for (int i = 0; i < 30; i++) begin
      int sz;
      sz = $urandom_range(0, 200);
      send_value(sz, words_of(sz), words_of(sz));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    wait_drain();
    cfg_bypass = 1'b1;
    repeat (3) @(negedge clk);
    exp_bypass = 1;
    for (int i = 0; i < 12; i++) begin
      int sz;
      sz = $urandom_range(0, 200);
      send_value(sz, words_of(sz), words_of(sz));
    end
    wait_drain();
    cfg_bypass = 1'b0;
    repeat (3) @(negedge clk);
    exp_bypass = 0;

    // Short value against a 5-word header, then reset while the frame is stuck mid-stream.
    ordy_mode = 1;
    send_value(122, 3, 5);
    repeat (8) @(negedge clk);
    chk("err_sticky", 192'(err_len), 192'(1));
    chk("stuck_busy", 192'(busy), 192'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 192'(out_valid), '0);
    chk("mid_rst_out_last", 192'(out_last), '0);
    chk("mid_rst_out_size", 192'(out_size), '0);
    chk("mid_rst_err_len", 192'(err_len), '0);
    chk("mid_rst_busy", 192'(busy), '0);
    chk("mid_rst_eng_res_ready", 192'(eng_res_ready), '0);
    @(negedge clk);
    rst = 1'b0;
    send_value(26, 1, 1);
    send_value(74, 3, 3);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "simulation timeout");
  end
endmodule
